inertial_cmd_seq: RTL and testbench
===================================

# inertial_cmd_seq

Command sequencer that drives the SPI monarch on behalf of the inertial sensor. After reset it waits for sensor power-up, issues three configuration writes, then services each data-ready interrupt by reading the yaw-rate low and high registers. It presents the assembled signed 16-bit yaw rate with a one-cycle valid pulse to the downstream heading logic. It sits between the heading/integrator logic and the SPI monarch, and owns that monarch's wrt/wt_data handshake.

## Interface
- INIT_WAIT, 16'hFFFF: clocks spent in power-up wait before the first config write. Range 1..65535. The bench uses 16.
- clk  in  1  50MHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- INT  in  1  sensor data-ready, asynchronous to clk, level-high
- done  in  1  SPI monarch done; sticky level, cleared by the monarch after the next wrt
- rd_data  in  16  SPI monarch read data; only [7:0] is used
- wrt  out  1  one-cycle pulse that starts an SPI transaction
- cmd  out  16  command word to the monarch's wt_data; held stable until the next wrt
- yaw_rt  out  16  signed yaw rate, {high byte, low byte}
- vld  out  1  one-cycle pulse when yaw_rt updates

## Operation
- INT passes through a 2-flop synchronizer (INT_ff1, INT_ff2). The FSM uses only INT_ff2.
- done_rise = done & ~done_q, where done_q is done registered once. All transaction-complete decisions use done_rise only. A stale high done during or after a wrt cycle must never advance the FSM.
- The 16-bit timer counts only in PWR and resets to 0 on exit.
- States and transitions (wrt/cmd are registered and issued on the transition edge):
  - PWR: when the timer reaches INIT_WAIT-1, go to CFG1 with wrt=1 and cmd=16'h0D02 (INT enable on data-ready).
  - CFG1: on done_rise, go to CFG2 with wrt=1 and cmd=16'h1160 (gyro ODR).
  - CFG2: on done_rise, go to CFG3 with wrt=1 and cmd=16'h1440 (rounding).
  - CFG3: on done_rise, go to IDLE. No wrt.
  - IDLE: while INT_ff2=1, go to RDL with wrt=1 and cmd=16'hA600.
  - RDL: on done_rise, latch yawL<=rd_data[7:0], then go to RDH with wrt=1 and cmd=16'hA700.
  - RDH: on done_rise, set yaw_rt<={rd_data[7:0], yawL} and vld<=1, then go to IDLE.
- vld clears automatically on the following cycle. yaw_rt holds its value until the next RDH completion.
- INT is level-sensitive. If INT_ff2 is still high on return to IDLE, a new read starts immediately.
- INT is ignored in PWR and all CFG states.
- rd_data[15:8] is always discarded.

## Timing
- Reset values: wrt=0, cmd=16'h0000, yaw_rt=16'h0000, vld=0, state=PWR, timer=0, yawL=0, INT_ff1/INT_ff2/done_q=0.
- The first wrt occurs exactly INIT_WAIT cycles after rst_n deasserts.
- wrt fires on the cycle immediately after the clock edge where done_rise was sampled, so there is one cycle of latency from done rising.
- INT rising to wrt takes 3 clocks: 2 synchronizer cycles plus 1 registered decision.
- vld is high on the cycle after the edge that sampled done_rise in RDH.
- An asserted rst_n at any point, including mid-transaction, returns every output to its reset value asynchronously. Operation restarts from PWR and all three config writes replay.
- The SPI monarch's own state is not this block's concern.

## Structure
- A shared package holds the state_t enum {PWR, CFG1, CFG2, CFG3, IDLE, RDL, RDH}.
- The same package holds the command constants CMD_INT_EN=16'h0D02, CMD_GYRO_ODR=16'h1160, CMD_ROUND=16'h1440, CMD_YAWL=16'hA600 and CMD_YAWH=16'hA700.
- The design is a single module with no sub-modules. The synchronizer and edge detect are inline flops.
- At top level, the SPI monarch is instantiated alongside this block, not inside it.

## Test plan
- Reset with INIT_WAIT=16 -> wrt stays 0 for 16 clocks after rst_n rises, then a single-cycle wrt with cmd=16'h0D02.
- The SPI model raises a sticky done 40 clocks after each wrt -> wrt with cmd 16'h1160 one cycle after done rises, then 16'h1440, then no further wrt while INT=0.
- INT raised in IDLE -> wrt with cmd=16'hA600 three clocks later. The model returns 16'h00CD, then cmd=16'hA700 follows. The model returns 16'h00AB -> vld high for exactly one cycle with yaw_rt=16'hABCD.
- Upper byte junk: returns 16'hFF12 then 16'hEE80 -> yaw_rt=16'h8012, which is negative.
- Stale done: the model keeps done high through the wrt cycle and lowers it 2 cycles later -> the FSM advances only on the subsequent done rise, with exactly one wrt per state.
- Reset asserted during RDH -> outputs zero immediately. After release, the INIT_WAIT delay and all three config writes repeat, with no vld until a new INT read completes.

Source files
------------

// File: rtl/inertial_cmd_seq_pkg.sv
// inertial_cmd_seq shared types: FSM states and SPI command words.
// No ports; imported by the sequencer and its bench.
package inertial_cmd_seq_pkg;

  typedef enum logic [2:0] {
    PWR,
    CFG1,
    CFG2,
    CFG3,
    IDLE,
    RDL,
    RDH
  } state_t;

  localparam logic [15:0] CMD_INT_EN   = 16'h0D02;
  localparam logic [15:0] CMD_GYRO_ODR = 16'h1160;
  localparam logic [15:0] CMD_ROUND    = 16'h1440;
  localparam logic [15:0] CMD_YAWL     = 16'hA600;
  localparam logic [15:0] CMD_YAWH     = 16'hA700;

endpackage

// File: rtl/inertial_cmd_seq_if.sv
// SPI monarch command handshake bundle.
// wrt/cmd: sequencer -> monarch; done/rd_data: monarch -> sequencer.
interface inertial_cmd_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_data
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_data
  );
endinterface

// File: rtl/inertial_cmd_seq.sv
// Inertial sensor command sequencer: power-up wait, 3 config writes,
// then a yaw-rate low/high read per data-ready interrupt.
// Ports: clk, rst_n (async low), INT (async level), spi (master bundle),
// yaw_rt (signed {hi,lo}), vld (1-cycle strobe on yaw_rt update).
module inertial_cmd_seq
  import inertial_cmd_seq_pkg::*;
#(
  parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      INT,
  inertial_cmd_seq_if.master        spi,
  output logic [15:0]               yaw_rt,
  output logic                      vld
);

  state_t      r_state;
  logic [15:0] r_timer;
  logic [7:0]  r_yawl;
  logic        r_int_ff1;
  logic        r_int_ff2;
  logic        r_done_q;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic [15:0] r_yaw_rt;
  logic        r_vld;

  logic        w_done_rise;
  logic        w_unused;

  // done is sticky and may still be high from the previous
  // transaction, so only its rising edge counts as completion.
  assign w_done_rise = spi.done & ~r_done_q;
  assign w_unused    = ^spi.rd_data[15:8];

  assign spi.wrt = r_wrt;
  assign spi.cmd = r_cmd;
  assign yaw_rt  = r_yaw_rt;
  assign vld     = r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= PWR;
      r_timer   <= 16'd0;
      r_yawl    <= 8'd0;
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_done_q  <= 1'b0;
      r_wrt     <= 1'b0;
      r_cmd     <= 16'h0000;
      r_yaw_rt  <= 16'h0000;
      r_vld     <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      r_done_q  <= spi.done;
      r_wrt     <= 1'b0;
      r_vld     <= 1'b0;
      unique case (r_state)
        PWR: begin
          if (r_timer == INIT_WAIT - 16'd1) begin
            r_timer <= 16'd0;
            r_state <= CFG1;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INT_EN;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        CFG1: begin
          if (w_done_rise) begin
            r_state <= CFG2;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_GYRO_ODR;
          end
        end
        CFG2: begin
          if (w_done_rise) begin
            r_state <= CFG3;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_ROUND;
          end
        end
        CFG3: begin
          if (w_done_rise) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (r_int_ff2) begin
            r_state <= RDL;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_YAWL;
          end
        end
        RDL: begin
          if (w_done_rise) begin
            r_yawl  <= spi.rd_data[7:0];
            r_state <= RDH;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_YAWH;
          end
        end
        RDH: begin
          if (w_done_rise) begin
            r_yaw_rt <= {spi.rd_data[7:0], r_yawl};
            r_vld    <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_inertial_cmd_seq.sv
// Directed + randomized bench for inertial_cmd_seq with a sticky-done
// SPI monarch model and a command/yaw scoreboard.
module tb_inertial_cmd_seq;
  import inertial_cmd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        int_in;
  logic [15:0] yaw_rt;
  logic        vld;

  inertial_cmd_seq_if spi();

  inertial_cmd_seq #(.INIT_WAIT(16'd16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .INT    (int_in),
    .spi    (spi),
    .yaw_rt (yaw_rt),
    .vld    (vld)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_wrt  = 0;
  int n_vld  = 0;
  logic [15:0] got_cmd[$];
  logic [15:0] exp_cmd[$];
  logic [15:0] got_yaw[$];
  logic [15:0] exp_yaw[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock, then sample outputs 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
    if (spi.wrt === 1'b1) begin
      n_wrt++;
      got_cmd.push_back(spi.cmd);
    end
    if (vld === 1'b1) begin
      n_vld++;
      got_yaw.push_back(yaw_rt);
    end
  endtask

  // monarch finishes: data appears with a sticky done
  task automatic serve(logic [15:0] rdv, int lat);
    repeat (lat) step();
    spi.rd_data = rdv;
    spi.done    = 1'b1;
  endtask

  // expect a wrt exactly exp_n clocks from now, one cycle wide
  task automatic wait_wrt(string tag, int exp_n, logic [15:0] c, bit stale);
    int n = 0;
    exp_cmd.push_back(c);
    do begin
      step();
      n++;
    end while (spi.wrt !== 1'b1 && n < 300);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_cmd"}, spi.cmd, c);
    if (!stale) spi.done = 1'b0;
    step();
    chk({tag, "_pulse"}, spi.wrt, 1'b0);
    if (stale) begin
      step();
      spi.done = 1'b0;
    end
  endtask

  task automatic cfg_seq(bit stale2);
    int w;
    wait_wrt("pwr", 16, CMD_INT_EN, 1'b0);
    serve(16'($urandom), 39);
    wait_wrt("cfg1", 1, CMD_GYRO_ODR, stale2);
    serve(16'($urandom), 39);
    wait_wrt("cfg2", 1, CMD_ROUND, 1'b0);
    serve(16'($urandom), 39);
    w = n_wrt;
    repeat (30) step();
    chk("idle_quiet", n_wrt, w);
  endtask

  task automatic start_read(bit hold);
    int_in = 1'b1;
    wait_wrt("int2wrt", 3, CMD_YAWL, 1'b0);
    if (!hold) int_in = 1'b0;
  endtask

  task automatic do_read(string tag, logic [15:0] lo, logic [15:0] hi,
                         int lat, bit stale, bit hold);
    logic [15:0] y;
    serve(lo, lat);
    wait_wrt({tag, "_yawh"}, 1, CMD_YAWH, stale);
    serve(hi, lat);
    y = {hi[7:0], lo[7:0]};
    exp_yaw.push_back(y);
    step();
    chk({tag, "_vld"}, vld, 1'b1);
    chk({tag, "_yaw"}, yaw_rt, y);
    step();
    chk({tag, "_vld_clr"}, vld, 1'b0);
    chk({tag, "_yaw_hold"}, yaw_rt, y);
    if (hold) begin
      exp_cmd.push_back(CMD_YAWL);
      chk({tag, "_b2b_wrt"}, spi.wrt, 1'b1);
      chk({tag, "_b2b_cmd"}, spi.cmd, CMD_YAWL);
      spi.done = 1'b0;
      int_in   = 1'b0;
      step();
      chk({tag, "_b2b_pulse"}, spi.wrt, 1'b0);
    end else begin
      chk({tag, "_no_wrt"}, spi.wrt, 1'b0);
    end
  endtask

  initial begin
    logic [15:0] lo;
    logic [15:0] hi;
    int v;
    int w;

    rst_n       = 1'b0;
    int_in      = 1'b0;
    spi.done    = 1'b0;
    spi.rd_data = 16'h0000;
    repeat (3) step();
    chk("rst_wrt", spi.wrt, 1'b0);
    chk("rst_cmd", spi.cmd, 16'h0000);
    chk("rst_yaw", yaw_rt, 16'h0000);
    chk("rst_vld", vld, 1'b0);
    rst_n = 1'b1;

    cfg_seq(1'b1);

    start_read(1'b0);
    do_read("abcd", 16'h00CD, 16'h00AB, 40, 1'b0, 1'b0);

    start_read(1'b0);
    do_read("junk", 16'hFF12, 16'hEE80, 40, 1'b0, 1'b0);
    chk("junk_neg", {31'd0, $signed(yaw_rt) < 0}, 1);

    start_read(1'b0);
    do_read("stale", 16'h3377, 16'h4411, 12, 1'b1, 1'b0);

    start_read(1'b1);
    do_read("b2b1", 16'($urandom), 16'($urandom), 8, 1'b0, 1'b1);
    do_read("b2b2", 16'($urandom), 16'($urandom), 8, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      lo = 16'($urandom);
      hi = 16'($urandom);
      start_read(1'b0);
      do_read("rnd", lo, hi, $urandom_range(2, 25), (i % 3) == 1, 1'b0);
    end

    start_read(1'b0);
    do_read("pre_rst", 16'h003C, 16'h005A, 10, 1'b0, 1'b0);

    // reset while waiting for the high byte
    start_read(1'b0);
    serve(16'h0011, 10);
    wait_wrt("rdh_rst_yawh", 1, CMD_YAWH, 1'b0);
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wrt", spi.wrt, 1'b0);
    chk("mid_rst_cmd", spi.cmd, 16'h0000);
    chk("mid_rst_yaw", yaw_rt, 16'h0000);
    chk("mid_rst_vld", vld, 1'b0);
    spi.done = 1'b0;
    int_in   = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    v = n_vld;
    cfg_seq(1'b0);
    w = n_wrt;
    repeat (20) step();
    chk("post_rst_no_vld", n_vld, v);
    chk("post_rst_no_wrt", n_wrt, w);

    start_read(1'b0);
    do_read("final", 16'($urandom), 16'($urandom), 15, 1'b0, 1'b0);

    chk("sb_cmd_count", got_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
      chk("sb_cmd", got_cmd[i], exp_cmd[i]);
    chk("sb_yaw_count", got_yaw.size(), exp_yaw.size());
    for (int i = 0; i < exp_yaw.size() && i < got_yaw.size(); i++)
      chk("sb_yaw", got_yaw[i], exp_yaw[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
